// File: rtl/rx_controller_ear.sv
// rtl/rx_controller_ear.sv - serial frame receiver: preamble/SFD lock, header, payload, CRC-8 check
// Recovers one frame at a time from the 1-bit line and delivers good, addressed frames as a 136-bit word.

module rx_controller_ear #(
  parameter logic [1:0] MY_ID    = 2'b01,
  parameter logic [1:0] BCAST_ID = 2'b11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_line,
  output logic [135:0] rx_packet,
  output logic         rx_valid,
  output logic         rx_crc_err,
  output logic         rx_busy
);

  typedef enum logic [2:0] {
    S_HUNT,
    S_HEADER,
    S_DATA,
    S_CRC,
    S_CHECK
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [15:0]    hunt_win;
  logic [7:0]     bit_cnt;
  logic [7:0]     crc;
  logic [7:0]     crc_rx;
  logic [7:0]     hdr;
  logic [127:0]   pay;

  logic [15:0]    hunt_shift;
  logic           lock;
  logic [7:0]     data_last;
  logic [7:0]     crc_nxt;
  logic           addr_ok;
  logic           crc_ok;
  logic [6:0]     align_amt;
  logic [127:0]   pay_aligned;

  // (LEN+1)*8-1 == LEN*8+7, and (15-LEN)*8 == ~LEN*8 for a 4-bit LEN
  always_comb begin
    hunt_shift  = {hunt_win[14:0], rx_line};
    lock        = (hunt_shift == 16'hAAAB);
    data_last   = {1'b0, hdr[3:0], 3'b111};
    crc_nxt     = {crc[6:0], 1'b0} ^ ((crc[7] ^ rx_line) ? 8'h07 : 8'h00);
    addr_ok     = (hdr[7:6] == MY_ID) || (hdr[7:6] == BCAST_ID);
    crc_ok      = (crc == crc_rx);
    align_amt   = {~hdr[3:0], 3'b000};
    pay_aligned = pay << align_amt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HUNT:   if (lock) state_nxt = S_HEADER;
      S_HEADER: if (bit_cnt == 8'd7) state_nxt = S_DATA;
      S_DATA:   if (bit_cnt == data_last) state_nxt = S_CRC;
      S_CRC:    if (bit_cnt == 8'd7) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = S_HUNT;
      default:  state_nxt = S_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hunt_win   <= 16'h0;
      bit_cnt    <= 8'h0;
      crc        <= 8'h0;
      crc_rx     <= 8'h0;
      hdr        <= 8'h0;
      pay        <= 128'h0;
      rx_packet  <= 136'h0;
      rx_valid   <= 1'b0;
      rx_crc_err <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_valid   <= 1'b0;
      rx_crc_err <= 1'b0;
      case (state)
        S_HUNT: begin
          rx_busy <= 1'b0;
          if (lock) begin
            hunt_win <= 16'h0;
            bit_cnt  <= 8'h0;
            crc      <= 8'h0;
            pay      <= 128'h0;
          end else begin
            hunt_win <= hunt_shift;
          end
        end
        S_HEADER: begin
          rx_busy <= 1'b1;
          hdr     <= {hdr[6:0], rx_line};
          bit_cnt <= (bit_cnt == 8'd7) ? 8'h0 : bit_cnt + 8'd1;
        end
        S_DATA: begin
          rx_busy <= 1'b1;
          pay     <= {pay[126:0], rx_line};
          crc     <= crc_nxt;
          bit_cnt <= (bit_cnt == data_last) ? 8'h0 : bit_cnt + 8'd1;
        end
        S_CRC: begin
          rx_busy <= 1'b1;
          crc_rx  <= {crc_rx[6:0], rx_line};
          bit_cnt <= (bit_cnt == 8'd7) ? 8'h0 : bit_cnt + 8'd1;
        end
        S_CHECK: begin
          rx_busy <= 1'b0;
          if (addr_ok && crc_ok) begin
            rx_packet <= {hdr, pay_aligned};
            rx_valid  <= 1'b1;
          end else if (addr_ok) begin
            rx_crc_err <= 1'b1;
          end
        end
        default: rx_busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_controller_ear.sv
// tb/tb_rx_controller_ear.sv - directed scoreboard bench for rx_controller_ear
// Frames are serialised bit by bit; expected pulses are queued at send time and matched by a monitor.

module tb_rx_controller_ear;

  logic         clk;
  logic         rst_n;
  logic         rx_line;
  logic [135:0] rx_packet;
  logic         rx_valid;
  logic         rx_crc_err;
  logic         rx_busy;

  typedef struct {
    logic         v;
    logic         e;
    logic [135:0] pkt;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [135:0] last_good = '0;
  logic [127:0] full_pay;

  rx_controller_ear #(.MY_ID(2'b01), .BCAST_ID(2'b11)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_line    (rx_line),
    .rx_packet  (rx_packet),
    .rx_valid   (rx_valid),
    .rx_crc_err (rx_crc_err),
    .rx_busy    (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [127:0] p, input int nbytes);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < nbytes * 8; i++)
      c = {c[6:0], 1'b0} ^ ((c[7] ^ p[127-i]) ? 8'h07 : 8'h00);
    return c;
  endfunction

  task automatic drive_bit(input logic b);
    rx_line = b;
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) drive_bit(v[i]);
  endtask

  task automatic send_preamble(input int npre);
    for (int i = 0; i < npre; i++) drive_bit(((npre - 1 - i) % 2) == 1);
    send_bits(32'hAB, 8);
  endtask

  // Payload is passed left-aligned, exactly as rx_packet should present it
  task automatic send_frame(input int npre, input logic [7:0] hdr, input logic [127:0] pay,
                            input logic [7:0] crc);
    int   nbytes;
    logic ok;
    nbytes = int'(hdr[3:0]) + 1;
    send_preamble(npre);
    send_bits({24'h0, hdr}, 8);
    for (int i = 0; i < nbytes * 8; i++) drive_bit(pay[127-i]);
    send_bits({24'h0, crc}, 8);
    ok = (hdr[7:6] == 2'b01) || (hdr[7:6] == 2'b11);
    if (ok && crc8(pay, nbytes) == crc) begin
      last_good = {hdr, pay};
      sb.push_back('{v: 1'b1, e: 1'b0, pkt: last_good, cyc: cyc + 1});
    end else if (ok) begin
      sb.push_back('{v: 1'b0, e: 1'b1, pkt: last_good, cyc: cyc + 1});
    end
  endtask

  task automatic settle(input string tag);
    send_bits(32'h0, 6);
    check({tag, "_pending"}, 136'(sb.size()), 136'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && (rx_valid || rx_crc_err)) begin
      check("unexpected_pulse", 136'(sb.size() > 0), 136'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("pulse_kind", {134'h0, rx_valid, rx_crc_err}, {134'h0, mon_e.v, mon_e.e});
        check("rx_packet", rx_packet, mon_e.pkt);
        check("pulse_cycle", 136'(cyc), 136'(mon_e.cyc));
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    rx_line = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_packet", rx_packet, 136'h0);
    check("rst_valid", 136'(rx_valid), 136'd0);
    check("rst_crc_err", 136'(rx_crc_err), 136'd0);
    check("rst_busy", 136'(rx_busy), 136'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send_frame(16, 8'h60, {8'h01, 120'h0}, 8'h07);
    settle("good");

    send_frame(16, 8'h60, {8'h81, 120'h0}, 8'h07);
    settle("crc_err");

    for (int i = 0; i < 16; i++) full_pay[127-8*i -: 8] = 8'(i * 37 + 5);
    send_frame(16, 8'h6F, full_pay, crc8(full_pay, 16));
    settle("full");

    send_frame(16, 8'hA0, {8'hFF, 120'h0}, 8'hF3);
    settle("addr_drop");
    check("addr_drop_busy", 136'(rx_busy), 136'd0);

    send_frame(16, 8'hE0, {8'hFF, 120'h0}, 8'hF3);
    settle("bcast");

    send_bits(32'hF0, 8);
    send_frame(8, 8'h60, {8'h01, 120'h0}, 8'h07);
    settle("pre8");

    send_preamble(6);
    send_bits(32'h0, 3);
    check("pre6_busy", 136'(rx_busy), 136'd0);
    send_bits(32'h0, 32);
    settle("pre6");

    send_frame(16, 8'hE0, {8'hFF, 120'h0}, 8'hF3);
    send_frame(16, 8'h60, {8'h01, 120'h0}, 8'h07);
    settle("b2b");

    send_preamble(16);
    send_bits(32'h6F, 8);
    send_bits(32'h123456, 24);
    check("mid_busy", 136'(rx_busy), 136'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_packet", rx_packet, 136'h0);
    check("mid_rst_valid", 136'(rx_valid), 136'd0);
    check("mid_rst_crc_err", 136'(rx_crc_err), 136'd0);
    check("mid_rst_busy", 136'(rx_busy), 136'd0);
    last_good = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(16, 8'h60, {8'h01, 120'h0}, 8'h07);
    settle("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
